// File: rtl/mult_pkg.sv
// Shared types and constants for the 4x4 sequential multiplier built on an
// external 2x2 cell.
package mult_pkg;

    localparam int OPW   = 4;   // operand width
    localparam int HALFW = 2;   // operand half width fed to the cell
    localparam int CELLW = 4;   // cell product width
    localparam int RESW  = 8;   // result width

    typedef logic [2:0] shift_t;

    // Encoding order matters: the skip logic walks steps in ascending order.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        LH   = 3'd2,
        HL   = 3'd3,
        HH   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam shift_t SHIFT_LL = 3'd0;
    localparam shift_t SHIFT_LH = 3'd2;
    localparam shift_t SHIFT_HL = 3'd2;
    localparam shift_t SHIFT_HH = 3'd4;

endpackage

// File: rtl/mult4_seq_ctrl_if.sv
// Operand/result valid-ready bundle between the source/sink and the controller.
interface mult4_seq_ctrl_if;
    import mult_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic            out_valid;
    logic            out_ready;
    logic [RESW-1:0] p;
    logic            ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, ovf
    );

endinterface

// File: rtl/mult4_pp_accum.sv
// Shift-add accumulator for partial products; the carry out of bit 7 is kept
// as a sticky overflow flag.
module mult4_pp_accum
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  shift_t           shift,
    input  logic [CELLW-1:0] pp,
    output logic [RESW-1:0]  p,
    output logic             ovf
);

    logic [RESW-1:0] acc_reg;
    logic            ovf_reg;
    logic [RESW:0]   pp_ext;
    logic [RESW:0]   sum;

    assign pp_ext = {{(RESW + 1 - CELLW){1'b0}}, pp} << shift;
    assign sum    = {1'b0, acc_reg} + pp_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (clr) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (en) begin
            acc_reg <= sum[RESW-1:0];
            ovf_reg <= ovf_reg | sum[RESW];
        end
    end

    assign p   = acc_reg;
    assign ovf = ovf_reg;

endmodule

// File: rtl/mult4_seq_ctrl.sv
// Sequences the four 2x2 partial products of a 4x4 multiply through one
// external cell, with optional skipping of steps that have a zero half.
module mult4_seq_ctrl
    import mult_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mult4_seq_ctrl_if.slave  bus,
    output logic             busy,
    output logic [HALFW-1:0] mul_a,
    output logic [HALFW-1:0] mul_b,
    input  logic [CELLW-1:0] mul_p
);

    state_t         state_reg, state_next;
    logic [OPW-1:0] a_reg, b_reg;
    logic           acc_clr, acc_en;
    shift_t         shift;

    function automatic logic step_live(logic [HALFW-1:0] x, logic [HALFW-1:0] y);
        return !SKIP_ZERO || ((x != '0) && (y != '0));
    endfunction

    // First live step strictly after s; later candidates are overridden by
    // earlier ones, so the lowest live step wins.
    function automatic state_t next_step(state_t s, logic [OPW-1:0] av, logic [OPW-1:0] bv);
        state_t nxt;
        nxt = DONE;
        if (s < HH && step_live(av[3:2], bv[3:2])) nxt = HH;
        if (s < HL && step_live(av[3:2], bv[1:0])) nxt = HL;
        if (s < LH && step_live(av[1:0], bv[3:2])) nxt = LH;
        if (s < LL && step_live(av[1:0], bv[1:0])) nxt = LL;
        return nxt;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.in_valid) begin
                a_reg <= bus.a;
                b_reg <= bus.b;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        shift      = SHIFT_LL;
        mul_a      = '0;
        mul_b      = '0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_clr    = 1'b1;
                    state_next = next_step(IDLE, bus.a, bus.b);
                end
            end
            LL: begin
                mul_a      = a_reg[1:0];
                mul_b      = b_reg[1:0];
                acc_en     = 1'b1;
                shift      = SHIFT_LL;
                state_next = next_step(LL, a_reg, b_reg);
            end
            LH: begin
                mul_a      = a_reg[1:0];
                mul_b      = b_reg[3:2];
                acc_en     = 1'b1;
                shift      = SHIFT_LH;
                state_next = next_step(LH, a_reg, b_reg);
            end
            HL: begin
                mul_a      = a_reg[3:2];
                mul_b      = b_reg[1:0];
                acc_en     = 1'b1;
                shift      = SHIFT_HL;
                state_next = next_step(HL, a_reg, b_reg);
            end
            HH: begin
                mul_a      = a_reg[3:2];
                mul_b      = b_reg[3:2];
                acc_en     = 1'b1;
                shift      = SHIFT_HH;
                state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    mult4_pp_accum u_accum (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .en    (acc_en),
        .shift (shift),
        .pp    (mul_p),
        .p     (bus.p),
        .ovf   (bus.ovf)
    );

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Randomized and directed bench for mult4_seq_ctrl: one instance without skipping
// (exact or stub cell), one with zero-term skipping (exact cell).
module tb_mult4_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult4_seq_ctrl_if if_n ();
    mult4_seq_ctrl_if if_s ();

    logic       busy_n, busy_s;
    logic [1:0] ma_n, mb_n, ma_s, mb_s;
    logic [3:0] mp_n, mp_s;
    logic       stub_sel;

    // Exact cell, or a stub that always answers 15.
    assign mp_n = stub_sel ? 4'd15 : ({2'b00, ma_n} * {2'b00, mb_n});
    assign mp_s = {2'b00, ma_s} * {2'b00, mb_s};

    logic       in_valid_t, out_ready_t;
    logic [3:0] a_t, b_t;
    int         sel;

    assign if_n.in_valid  = in_valid_t && (sel == 0);
    assign if_s.in_valid  = in_valid_t && (sel == 1);
    assign if_n.out_ready = out_ready_t && (sel == 0);
    assign if_s.out_ready = out_ready_t && (sel == 1);
    assign if_n.a = a_t;
    assign if_n.b = b_t;
    assign if_s.a = a_t;
    assign if_s.b = b_t;

    logic       o_in_ready, o_out_valid, o_ovf, o_busy;
    logic [7:0] o_p;
    logic [1:0] o_ma, o_mb;
    assign o_in_ready  = (sel == 1) ? if_s.in_ready  : if_n.in_ready;
    assign o_out_valid = (sel == 1) ? if_s.out_valid : if_n.out_valid;
    assign o_ovf       = (sel == 1) ? if_s.ovf       : if_n.ovf;
    assign o_p         = (sel == 1) ? if_s.p         : if_n.p;
    assign o_busy      = (sel == 1) ? busy_s         : busy_n;
    assign o_ma        = (sel == 1) ? ma_s           : ma_n;
    assign o_mb        = (sel == 1) ? mb_s           : mb_n;

    mult4_seq_ctrl #(.SKIP_ZERO(1'b0)) dut_n (
        .clk   (clk),
        .rst   (rst),
        .bus   (if_n.slave),
        .busy  (busy_n),
        .mul_a (ma_n),
        .mul_b (mb_n),
        .mul_p (mp_n)
    );

    mult4_seq_ctrl #(.SKIP_ZERO(1'b1)) dut_s (
        .clk   (clk),
        .rst   (rst),
        .bus   (if_s.slave),
        .busy  (busy_s),
        .mul_a (ma_s),
        .mul_b (mb_s),
        .mul_p (mp_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: sum of every executed 2x2 partial product at its weight.
    // Additions only grow the sum, so a carry out of bit 7 ever happening is
    // the same as the total reaching 256.
    task automatic model(input bit skip, input bit stub, input int av, input int bv,
                         output int p_exp, output int ovf_exp, output int lat_exp);
        int sum, ah, bh, n;
        sum = 0;
        n   = 0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                ah = (av >> (2 * i)) & 3;
                bh = (bv >> (2 * j)) & 3;
                if (!(skip && (ah == 0 || bh == 0))) begin
                    sum += (stub ? 15 : ah * bh) << (2 * (i + j));
                    n++;
                end
            end
        end
        p_exp   = sum % 256;
        ovf_exp = (sum > 255) ? 1 : 0;
        lat_exp = (n == 0) ? 1 : n;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (!o_in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", int'(o_in_ready), 1);
    endtask

    // One full transaction: accept, step latency, result, DONE hold, release.
    task automatic run_op(input int s, input bit stub, input int av, input int bv,
                          input int hold, input bit jam);
        int p_exp, ovf_exp, lat_exp, n;
        bit got;
        wait_idle();
        sel         = s;
        stub_sel    = stub;
        out_ready_t = 1'b0;
        in_valid_t  = 1'b1;
        a_t         = 4'(av);
        b_t         = 4'(bv);
        model(s == 1, stub, av, bv, p_exp, ovf_exp, lat_exp);
        @(posedge clk);
        #1;
        if (!jam) in_valid_t = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 8 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (o_out_valid) begin
                got = 1'b1;
            end else begin
                check("busy_step", int'(o_busy), 1);
                check("in_ready_step", int'(o_in_ready), 0);
            end
            if (jam) begin
                a_t = 4'($urandom);
                b_t = 4'($urandom);
            end
        end
        check("out_valid_seen", int'(got), 1);
        check("latency", n, lat_exp);
        check("p", int'(o_p), p_exp);
        check("ovf", int'(o_ovf), ovf_exp);
        check("mul_a_done", int'(o_ma), 0);
        check("mul_b_done", int'(o_mb), 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", int'(o_out_valid), 1);
            check("hold_p", int'(o_p), p_exp);
            check("hold_ovf", int'(o_ovf), ovf_exp);
        end
        in_valid_t  = 1'b0;
        out_ready_t = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_t = 1'b0;
        check("released", int'(o_out_valid), 0);
        check("in_ready_after", int'(o_in_ready), 1);
        $display("op dut=%0d stub=%0d a=%0d b=%0d hold=%0d jam=%0d -> p=%0d ovf=%0d lat=%0d (exp p=%0d ovf=%0d lat=%0d)",
                 s, stub, av, bv, hold, jam, o_p, o_ovf, n, p_exp, ovf_exp, lat_exp);
    endtask

    initial begin
        rst         = 1'b1;
        sel         = 0;
        stub_sel    = 1'b0;
        in_valid_t  = 1'b0;
        out_ready_t = 1'b0;
        a_t         = '0;
        b_t         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready_n", int'(if_n.in_ready), 1);
        check("rst_out_valid_n", int'(if_n.out_valid), 0);
        check("rst_busy_n", int'(busy_n), 0);
        check("rst_p_n", int'(if_n.p), 0);
        check("rst_ovf_n", int'(if_n.ovf), 0);
        check("rst_mul_n", int'({ma_n, mb_n}), 0);
        check("rst_in_ready_s", int'(if_s.in_ready), 1);
        check("rst_busy_s", int'(busy_s), 0);
        rst = 1'b0;

        run_op(0, 1'b0, 13, 11, 0, 1'b0);
        run_op(0, 1'b0, 15, 15, 3, 1'b0);
        run_op(1, 1'b0, 3, 12, 0, 1'b0);
        run_op(1, 1'b0, 0, 9, 0, 1'b0);
        run_op(0, 1'b1, 15, 15, 0, 1'b0);
        run_op(0, 1'b0, 9, 5, 2, 1'b1);
        run_op(1, 1'b0, 10, 7, 1, 1'b1);

        // Reset while the HL step is on the cell.
        wait_idle();
        sel        = 0;
        stub_sel   = 1'b0;
        in_valid_t = 1'b1;
        a_t        = 4'd13;
        b_t        = 4'd11;
        @(posedge clk);
        #1;
        in_valid_t = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hl_mul_a", int'(o_ma), 3);
        check("hl_mul_b", int'(o_mb), 3);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(o_out_valid), 0);
        check("midrst_p", int'(o_p), 0);
        check("midrst_in_ready", int'(o_in_ready), 1);
        check("midrst_busy", int'(o_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("postrst_out_valid", int'(o_out_valid), 0);
        end
        run_op(0, 1'b0, 6, 7, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int s;
            s = int'($urandom_range(1, 0));
            run_op(s, (s == 0) ? 1'($urandom) : 1'b0,
                   int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(2, 0)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
